// File: rtl/projectile_pkg.sv
// Shared types and constants for the projectile pool controller and its cover search.
package projectile_pkg;
   localparam int COORD_W  = 11;
   localparam int OBJ_SIZE = 32;
   localparam int OFF_W    = $clog2(OBJ_SIZE);
   localparam int SCREEN_H = 480;

   typedef logic signed [COORD_W-1:0] coord_t;

   typedef enum logic { OWN_PLAYER = 1'b0, OWN_ENEMY = 1'b1 } owner_e;

   typedef enum logic { IDLE = 1'b0, UPDATE = 1'b1 } state_e;

   typedef struct packed {
      logic   active;
      owner_e owner;
      coord_t x;
      coord_t y;
   } slot_t;

   // org <= pos < org + OBJ_SIZE, evaluated in 32 bits so the span end cannot wrap.
   function automatic logic in_span(input coord_t pos, input coord_t org);
      int p;
      int o;
      p = int'(pos);
      o = int'(org);
      return (p >= o) && (p < o + OBJ_SIZE);
   endfunction
endpackage

// File: rtl/projectile_hit_finder.sv
// Combinational priority search: lowest-index active slot covering the pixel, plus offsets.
module projectile_hit_finder
   import projectile_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int IDX_W     = 2
) (
   input  slot_t [NUM_SLOTS-1:0]     slots_i,
   input  logic signed [COORD_W-1:0] pix_x_i,
   input  logic signed [COORD_W-1:0] pix_y_i,
   output logic                      hit_o,
   output logic [IDX_W-1:0]          idx_o,
   output logic [OFF_W-1:0]          off_x_o,
   output logic [OFF_W-1:0]          off_y_o,
   output logic                      enemy_o
);

   always_comb begin
      hit_o   = 1'b0;
      idx_o   = '0;
      off_x_o = '0;
      off_y_o = '0;
      enemy_o = 1'b0;
      // Walk downwards so the lowest covering index is the last one written.
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         if (slots_i[k].active && in_span(pix_x_i, slots_i[k].x) && in_span(pix_y_i, slots_i[k].y)) begin
            hit_o   = 1'b1;
            idx_o   = IDX_W'(k);
            off_x_o = OFF_W'(int'(pix_x_i) - int'(slots_i[k].x));
            off_y_o = OFF_W'(int'(pix_y_i) - int'(slots_i[k].y));
            enemy_o = (slots_i[k].owner == OWN_ENEMY);
         end
      end
   end

endmodule

// File: rtl/projectile_pool_ctrl.sv
// Projectile slot pool: fire arbitration, per-frame slot walk, collision retire, 1-cycle render lookup.
module projectile_pool_ctrl
   import projectile_pkg::*;
#(
   parameter int NUM_SLOTS    = 4,
   parameter int PLAYER_SPEED = 4,
   parameter int ENEMY_SPEED  = 2
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      startOfFrame,
   input  logic                      player_fire,
   input  logic signed [COORD_W-1:0] player_x,
   input  logic signed [COORD_W-1:0] player_y,
   input  logic                      enemy_fire,
   input  logic signed [COORD_W-1:0] enemy_x,
   input  logic signed [COORD_W-1:0] enemy_y,
   output logic                      player_ack,
   output logic                      enemy_ack,
   input  logic signed [COORD_W-1:0] pixelX,
   input  logic signed [COORD_W-1:0] pixelY,
   input  logic                      collision,
   output logic                      drawingRequest,
   output logic [OFF_W-1:0]          offsetX,
   output logic [OFF_W-1:0]          offsetY,
   output logic                      is_enemy,
   output logic [3:0]                active_count
);

   localparam int               IDX_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

   state_e                state_q;
   logic [IDX_W-1:0]      idx_q;
   slot_t [NUM_SLOTS-1:0] slots_q;
   slot_t [NUM_SLOTS-1:0] slots_d;
   logic                  pend_p_q;
   logic                  pend_e_q;
   coord_t                px_q;
   coord_t                py_q;
   coord_t                ex_q;
   coord_t                ey_q;
   owner_e                rr_q;
   logic                  p_ack_q;
   logic                  e_ack_q;
   logic                  draw_q;
   logic                  enemy_q;
   logic [OFF_W-1:0]      offx_q;
   logic [OFF_W-1:0]      offy_q;
   logic [IDX_W-1:0]      hit_slot_q;
   logic [3:0]            count_q;

   logic [NUM_SLOTS-1:0]  active_vec;
   logic [NUM_SLOTS-1:0]  clr_mask;
   logic [NUM_SLOTS-1:0]  free_vec;
   logic                  any_free;
   logic [IDX_W-1:0]      free_idx;
   logic                  both;
   logic                  serve;
   logic                  sel_enemy;
   logic                  grant;
   logic                  drop;
   int                    upd_y;

   logic                  hit;
   logic [IDX_W-1:0]      hit_idx;
   logic [OFF_W-1:0]      hit_offx;
   logic [OFF_W-1:0]      hit_offy;
   logic                  hit_enemy;

   projectile_hit_finder #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) u_hit_finder (
      .slots_i (slots_q),
      .pix_x_i (pixelX),
      .pix_y_i (pixelY),
      .hit_o   (hit),
      .idx_o   (hit_idx),
      .off_x_o (hit_offx),
      .off_y_o (hit_offy),
      .enemy_o (hit_enemy)
   );

   // A slot being cleared by a collision this cycle is never offered to a grant.
   always_comb begin
      active_vec = '0;
      clr_mask   = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         active_vec[k] = slots_q[k].active;
      end
      if (collision && draw_q) begin
         clr_mask[hit_slot_q] = 1'b1;
      end
      free_vec = ~active_vec & ~clr_mask;
      any_free = |free_vec;
      free_idx = '0;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         if (free_vec[k]) begin
            free_idx = IDX_W'(k);
         end
      end
   end

   always_comb begin
      both      = pend_p_q & pend_e_q;
      serve     = (state_q == IDLE) && !startOfFrame && (pend_p_q || pend_e_q);
      sel_enemy = both ? (rr_q == OWN_ENEMY) : pend_e_q;
      grant     = serve && any_free;
      drop      = serve && !any_free;
   end

   always_comb begin
      slots_d = slots_q;
      upd_y   = 0;
      if (state_q == UPDATE && slots_q[idx_q].active) begin
         if (slots_q[idx_q].owner == OWN_PLAYER) begin
            upd_y = int'(slots_q[idx_q].y) - PLAYER_SPEED;
            slots_d[idx_q].active = (upd_y + OBJ_SIZE > 0);
         end else begin
            upd_y = int'(slots_q[idx_q].y) + ENEMY_SPEED;
            slots_d[idx_q].active = (upd_y < SCREEN_H);
         end
         slots_d[idx_q].y = COORD_W'(upd_y);
      end
      if (grant) begin
         slots_d[free_idx].active = 1'b1;
         slots_d[free_idx].owner  = sel_enemy ? OWN_ENEMY : OWN_PLAYER;
         slots_d[free_idx].x      = sel_enemy ? ex_q : px_q;
         slots_d[free_idx].y      = sel_enemy ? ey_q : py_q;
      end
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (clr_mask[k]) begin
            slots_d[k].active = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         slots_q    <= '0;
         pend_p_q   <= 1'b0;
         pend_e_q   <= 1'b0;
         px_q       <= '0;
         py_q       <= '0;
         ex_q       <= '0;
         ey_q       <= '0;
         rr_q       <= OWN_PLAYER;
         p_ack_q    <= 1'b0;
         e_ack_q    <= 1'b0;
         draw_q     <= 1'b0;
         enemy_q    <= 1'b0;
         offx_q     <= '0;
         offy_q     <= '0;
         hit_slot_q <= '0;
         count_q    <= '0;
      end else begin
         slots_q <= slots_d;
         count_q <= 4'($countones(active_vec));
         p_ack_q <= grant && !sel_enemy;
         e_ack_q <= grant && sel_enemy;

         // First pulse wins: a pending requester keeps its original coordinates.
         if (!pend_p_q && player_fire) begin
            pend_p_q <= 1'b1;
            px_q     <= player_x;
            py_q     <= player_y;
         end
         if (!pend_e_q && enemy_fire) begin
            pend_e_q <= 1'b1;
            ex_q     <= enemy_x;
            ey_q     <= enemy_y;
         end
         if ((grant && !sel_enemy) || (drop && pend_p_q)) begin
            pend_p_q <= 1'b0;
         end
         if ((grant && sel_enemy) || (drop && pend_e_q)) begin
            pend_e_q <= 1'b0;
         end
         if (grant && both) begin
            rr_q <= (rr_q == OWN_PLAYER) ? OWN_ENEMY : OWN_PLAYER;
         end

         case (state_q)
            IDLE: begin
               if (startOfFrame) begin
                  state_q <= UPDATE;
                  idx_q   <= '0;
               end
            end
            UPDATE: begin
               if (idx_q == LAST_IDX) begin
                  state_q <= IDLE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase

         draw_q     <= hit;
         enemy_q    <= hit_enemy;
         offx_q     <= hit_offx;
         offy_q     <= hit_offy;
         hit_slot_q <= hit_idx;
      end
   end

   assign player_ack     = p_ack_q;
   assign enemy_ack      = e_ack_q;
   assign drawingRequest = draw_q;
   assign offsetX        = offx_q;
   assign offsetY        = offy_q;
   assign is_enemy       = enemy_q;
   assign active_count   = count_q;

endmodule

// File: tb/tb_projectile_pool_ctrl.sv
// Directed bench for projectile_pool_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_projectile_pool_ctrl;
   logic clk = 1'b0;
   logic resetN = 1'b0;
   logic startOfFrame = 1'b0;
   logic player_fire = 1'b0;
   logic enemy_fire = 1'b0;
   logic collision = 1'b0;
   logic signed [10:0] player_x = '0;
   logic signed [10:0] player_y = '0;
   logic signed [10:0] enemy_x = '0;
   logic signed [10:0] enemy_y = '0;
   logic signed [10:0] pixelX = '0;
   logic signed [10:0] pixelY = '0;
   logic player_ack, enemy_ack, drawingRequest, is_enemy;
   logic [4:0] offsetX, offsetY;
   logic [3:0] active_count;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   projectile_pool_ctrl dut (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame   (startOfFrame),
      .player_fire    (player_fire),
      .player_x       (player_x),
      .player_y       (player_y),
      .enemy_fire     (enemy_fire),
      .enemy_x        (enemy_x),
      .enemy_y        (enemy_y),
      .player_ack     (player_ack),
      .enemy_ack      (enemy_ack),
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .collision      (collision),
      .drawingRequest (drawingRequest),
      .offsetX        (offsetX),
      .offsetY        (offsetY),
      .is_enemy       (is_enemy),
      .active_count   (active_count)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      startOfFrame = 0; player_fire = 0; enemy_fire = 0; collision = 0;
      pixelX = 0; pixelY = 0;
      resetN = 0;
      tick(); tick();
      resetN = 1;
      tick();
   endtask

   task automatic spawn(input bit enemy, input int x, input int y);
      if (enemy) begin
         enemy_x = 11'(x); enemy_y = 11'(y); enemy_fire = 1;
      end else begin
         player_x = 11'(x); player_y = 11'(y); player_fire = 1;
      end
      tick();
      player_fire = 0; enemy_fire = 0;
      tick(); tick();
   endtask

   task automatic walk();
      startOfFrame = 1;
      tick();
      startOfFrame = 0;
      repeat (5) tick();
   endtask

   task automatic set_pix(input int x, input int y);
      pixelX = 11'(x); pixelY = 11'(y);
      tick();
   endtask

   task automatic test_reset();
      resetN = 0;
      tick(); tick();
      checks++; if ({drawingRequest, offsetX, offsetY, is_enemy, player_ack, enemy_ack, active_count} !== 18'd0) begin
         failures++; $display("FAIL reset_outputs got=%h exp=0", {drawingRequest, offsetX, offsetY, is_enemy, player_ack, enemy_ack, active_count}); end
      resetN = 1;
      tick();
      checks++; if (active_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", active_count); end
   endtask

   task automatic test_fire_render();
      do_reset();
      player_x = 100; player_y = 400; player_fire = 1;
      tick();
      player_fire = 0;
      checks++; if (player_ack !== 1'b0) begin failures++; $display("FAIL fire_ack_t1 got=%0b exp=0", player_ack); end
      tick();
      checks++; if (player_ack !== 1'b1) begin failures++; $display("FAIL fire_ack_t2 got=%0b exp=1", player_ack); end
      checks++; if (enemy_ack !== 1'b0) begin failures++; $display("FAIL fire_enemy_ack got=%0b exp=0", enemy_ack); end
      tick();
      checks++; if (player_ack !== 1'b0) begin failures++; $display("FAIL fire_ack_t3 got=%0b exp=0", player_ack); end
      checks++; if (active_count !== 4'd1) begin failures++; $display("FAIL fire_count got=%0d exp=1", active_count); end
      set_pix(110, 405);
      checks++; if ({drawingRequest, offsetX, offsetY, is_enemy} !== {1'b1, 5'd10, 5'd5, 1'b0}) begin
         failures++; $display("FAIL render_basic got=%0b/%0d/%0d/%0b exp=1/10/5/0", drawingRequest, offsetX, offsetY, is_enemy); end
   endtask

   task automatic test_update();
      do_reset();
      spawn(0, 100, 400);
      startOfFrame = 1;
      tick();
      startOfFrame = 0;
      tick();
      // second frame pulse and a fire both land mid-walk
      startOfFrame = 1; player_x = 50; player_y = 300; player_fire = 1;
      tick();
      startOfFrame = 0; player_fire = 0;
      tick(); tick();
      checks++; if (player_ack !== 1'b0) begin failures++; $display("FAIL upd_pending_early got=%0b exp=0", player_ack); end
      tick();
      checks++; if (player_ack !== 1'b1) begin failures++; $display("FAIL upd_pending_ack got=%0b exp=1", player_ack); end
      set_pix(100, 396);
      checks++; if ({drawingRequest, offsetX, offsetY, is_enemy} !== {1'b1, 5'd0, 5'd0, 1'b0}) begin
         failures++; $display("FAIL upd_y396 got=%0b/%0d/%0d/%0b exp=1/0/0/0", drawingRequest, offsetX, offsetY, is_enemy); end
      set_pix(100, 395);
      checks++; if ({drawingRequest, offsetX, offsetY} !== 11'd0) begin
         failures++; $display("FAIL upd_above got=%0b/%0d/%0d exp=0/0/0", drawingRequest, offsetX, offsetY); end

      do_reset();
      spawn(0, 100, -30);
      spawn(0, 200, -28);
      spawn(0, 300, -27);
      checks++; if (active_count !== 4'd3) begin failures++; $display("FAIL top_count_pre got=%0d exp=3", active_count); end
      walk();
      checks++; if (active_count !== 4'd1) begin failures++; $display("FAIL top_count_post got=%0d exp=1", active_count); end
      set_pix(300, 0);
      checks++; if ({drawingRequest, offsetX, offsetY} !== {1'b1, 5'd0, 5'd31}) begin
         failures++; $display("FAIL top_neg_y got=%0b/%0d/%0d exp=1/0/31", drawingRequest, offsetX, offsetY); end
      set_pix(300, 1);
      checks++; if (drawingRequest !== 1'b0) begin failures++; $display("FAIL top_edge got=%0b exp=0", drawingRequest); end

      do_reset();
      spawn(1, 10, 476);
      walk();
      checks++; if (active_count !== 4'd1) begin failures++; $display("FAIL bot_478 got=%0d exp=1", active_count); end
      walk();
      checks++; if (active_count !== 4'd0) begin failures++; $display("FAIL bot_480 got=%0d exp=0", active_count); end
   endtask

   task automatic test_round_robin_and_full();
      do_reset();
      player_x = 10; player_y = 20; enemy_x = 300; enemy_y = 40;
      player_fire = 1; enemy_fire = 1;
      tick();
      player_fire = 0; enemy_fire = 0;
      tick();
      checks++; if ({player_ack, enemy_ack} !== 2'b10) begin failures++; $display("FAIL rr1_first got=%b exp=10", {player_ack, enemy_ack}); end
      tick();
      checks++; if ({player_ack, enemy_ack} !== 2'b01) begin failures++; $display("FAIL rr1_second got=%b exp=01", {player_ack, enemy_ack}); end
      player_x = 400; player_y = 200; enemy_x = 500; enemy_y = 300;
      player_fire = 1; enemy_fire = 1;
      tick();
      player_fire = 0; enemy_fire = 0;
      tick();
      checks++; if ({player_ack, enemy_ack} !== 2'b01) begin failures++; $display("FAIL rr2_first got=%b exp=01", {player_ack, enemy_ack}); end
      tick();
      checks++; if ({player_ack, enemy_ack} !== 2'b10) begin failures++; $display("FAIL rr2_second got=%b exp=10", {player_ack, enemy_ack}); end
      tick();
      checks++; if (active_count !== 4'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", active_count); end

      enemy_x = 600; enemy_y = 50; enemy_fire = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         enemy_fire = 0;
         checks++; if (enemy_ack !== 1'b0) begin failures++; $display("FAIL full_noack_%0d got=%0b exp=0", i, enemy_ack); end
      end
      checks++; if (active_count !== 4'd4) begin failures++; $display("FAIL full_count_keep got=%0d exp=4", active_count); end

      set_pix(10, 20);
      checks++; if ({drawingRequest, is_enemy} !== 2'b10) begin failures++; $display("FAIL full_slot0 got=%b exp=10", {drawingRequest, is_enemy}); end
      collision = 1;
      tick();
      collision = 0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (enemy_ack !== 1'b0) begin failures++; $display("FAIL drop_stale_%0d got=%0b exp=0", i, enemy_ack); end
         if (i < 2) tick();
      end
      checks++; if (active_count !== 4'd3) begin failures++; $display("FAIL drop_count got=%0d exp=3", active_count); end
      spawn(1, 600, 50);
      checks++; if (active_count !== 4'd4) begin failures++; $display("FAIL refill_count got=%0d exp=4", active_count); end
      set_pix(600, 50);
      checks++; if ({drawingRequest, is_enemy, offsetX, offsetY} !== {2'b11, 10'd0}) begin
         failures++; $display("FAIL refill_render got=%0b/%0b/%0d/%0d exp=1/1/0/0", drawingRequest, is_enemy, offsetX, offsetY); end
   endtask

   task automatic test_priority_collision();
      do_reset();
      spawn(1, 200, 100);
      spawn(0, 210, 110);
      set_pix(231, 131);
      checks++; if ({drawingRequest, is_enemy, offsetX, offsetY} !== {2'b11, 5'd31, 5'd31}) begin
         failures++; $display("FAIL edge_in got=%0b/%0b/%0d/%0d exp=1/1/31/31", drawingRequest, is_enemy, offsetX, offsetY); end
      set_pix(232, 100);
      checks++; if (drawingRequest !== 1'b0) begin failures++; $display("FAIL edge_out got=%0b exp=0", drawingRequest); end
      set_pix(215, 115);
      checks++; if ({drawingRequest, is_enemy, offsetX, offsetY} !== {2'b11, 5'd15, 5'd15}) begin
         failures++; $display("FAIL prio_low got=%0b/%0b/%0d/%0d exp=1/1/15/15", drawingRequest, is_enemy, offsetX, offsetY); end
      collision = 1;
      tick();
      collision = 0;
      tick();
      checks++; if ({drawingRequest, is_enemy, offsetX, offsetY} !== {2'b10, 5'd5, 5'd5}) begin
         failures++; $display("FAIL hit_other got=%0b/%0b/%0d/%0d exp=1/0/5/5", drawingRequest, is_enemy, offsetX, offsetY); end
      checks++; if (active_count !== 4'd1) begin failures++; $display("FAIL hit_count got=%0d exp=1", active_count); end
      set_pix(0, 0);
      collision = 1;
      tick();
      collision = 0;
      tick(); tick();
      checks++; if (active_count !== 4'd1) begin failures++; $display("FAIL miss_collision got=%0d exp=1", active_count); end
   endtask

   task automatic test_reset_mid_update();
      do_reset();
      spawn(0, 100, 200);
      set_pix(105, 205);
      startOfFrame = 1;
      tick();
      startOfFrame = 0;
      tick(); tick();
      checks++; if ({drawingRequest, active_count} !== {1'b1, 4'd1}) begin
         failures++; $display("FAIL mid_pre got=%0b/%0d exp=1/1", drawingRequest, active_count); end
      resetN = 0;
      #1;
      checks++; if ({drawingRequest, offsetX, offsetY, is_enemy, player_ack, enemy_ack, active_count} !== 18'd0) begin
         failures++; $display("FAIL mid_async got=%h exp=0", {drawingRequest, offsetX, offsetY, is_enemy, player_ack, enemy_ack, active_count}); end
      tick();
      resetN = 1;
      tick();
      checks++; if ({drawingRequest, active_count} !== 5'd0) begin
         failures++; $display("FAIL mid_after got=%0b/%0d exp=0/0", drawingRequest, active_count); end
      player_x = 10; player_y = 10; player_fire = 1;
      tick();
      player_fire = 0;
      tick();
      checks++; if (player_ack !== 1'b1) begin failures++; $display("FAIL mid_refire got=%0b exp=1", player_ack); end
   endtask

   initial begin
      test_reset();
      test_fire_render();
      test_update();
      test_round_robin_and_full();
      test_priority_collision();
      test_reset_mid_update();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
